reaction_trial_sequencer: RTL and testbench
===========================================

# reaction_trial_sequencer

Controller that sequences one reaction-time trial end to end: arms on the start button, waits a pseudo-random foreperiod, lights the go LED and starts the millisecond timer, then stops it on the react press or on timeout. It detects false starts, holds error indication, and tracks the session's best time. It replaces the bare FSM ahead of the timer and 7-segment driver, producing `start_timer`/`stop_timer` pulses and the values the display selects between.

## Interface
- `TICK_DIV`, 50000: clk cycles per 1 ms tick.
- `MIN_DELAY_MS`, 1000: fixed part of the foreperiod.
- `RAND_BITS`, 11: LFSR bits added to the foreperiod, giving 0..2^RAND_BITS-1 ms.
- `TIMEOUT_MS`, 2000: maximum wait in GO.
- `ERR_HOLD_MS`, 1500: duration of the error display.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start_btn` in 1: debounced level; the block detects rising edges.
- `react_btn` in 1: debounced level; the block detects rising edges.
- `ms_time` in 14: running count from the timer.
- `start_timer` out 1: one-cycle pulse that clears and starts the timer.
- `stop_timer` out 1: one-cycle pulse that freezes the timer.
- `led` out 1: go light.
- `show_error` out 1: high in FALSE_START or TIMEOUT.
- `done` out 1: high in RESULT.
- `result` out 14: last valid reaction time in ms.
- `best` out 14: minimum valid result since reset.
- `state_out` out 3: state encoding.

## Operation
- States and encodings: IDLE=0, WAIT=1, GO=2, RESULT=3, FALSE_START=4, TIMEOUT=5.
- Edge detect: `start_btn` and `react_btn` are each registered once; rise = current level & ~previous level.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Seed 16'hACE1 on reset. Advances every clk and never loads zero.
- IDLE or RESULT + start rise -> WAIT:
  - latch target = MIN_DELAY_MS + lfsr[RAND_BITS-1:0];
  - clear the ms divider and the ms counter.
- WAIT:
  - react rise -> FALSE_START;
  - else ms counter == target -> GO;
  - react rise wins if both occur in the same cycle;
  - start rise is ignored.
- GO:
  - `led`=1;
  - `start_timer` pulses in the first GO cycle;
  - the ms counter restarts at 0.
- GO + react rise -> RESULT:
  - `stop_timer` pulses;
  - `result` <= min(ms_time, 9999), sampled in the react-rise cycle;
  - if that value < `best`, `best` takes it in the same cycle.
- GO + ms counter == TIMEOUT_MS -> TIMEOUT:
  - `stop_timer` pulses;
  - `result` and `best` are unchanged;
  - react rise wins over timeout in the same cycle.
- FALSE_START / TIMEOUT:
  - `show_error`=1 for ERR_HOLD_MS ms ticks, then -> IDLE;
  - all button edges are ignored during the hold.
- RESULT: `done`=1 and `result` is held until the next start rise.
- The react button in IDLE or RESULT is ignored.
- `reset` at any point returns every state and output to its reset value, including `best`, and the LFSR reseeds.

## Timing
- Reset values:
  - state=IDLE;
  - `start_timer`=0, `stop_timer`=0, `led`=0, `show_error`=0, `done`=0;
  - `result`=0, `best`=9999, `state_out`=0.
- All outputs are registered and change in the same cycle as `state_out`.
- Button to state: a rise registered at edge k gives a state change visible after edge k+1 (one cycle).
- ms tick: a single-cycle strobe when the divider reaches TICK_DIV-1, then the divider wraps to 0. The WAIT duration is therefore exactly target*TICK_DIV cycles, ±1 cycle for the edge-detect latency.
- Counters: ms counter is 14 bits and saturates at 16383; target is at most MIN_DELAY_MS + 2^RAND_BITS - 1, which must be < 16384.
- `start_timer` and `stop_timer` are never high in the same cycle; each is high for exactly 1 cycle per transition.

## Structure
- Shared `reaction_pkg` holds:
  - state localparams;
  - `BEST_RESET`=9999 and `DISP_MAX`=9999;
  - `TIME_W`=14;
  - the LFSR seed and tap mask.
- Sub-module `ms_tick_gen` (parameter `TICK_DIV`; ports `clk`, `reset`, `clr` in; `tick` out) provides the clearable divider. The sequencer instantiates it once.

## Test plan
Sim parameters: `TICK_DIV`=4, `MIN_DELAY_MS`=10, `RAND_BITS`=3, `TIMEOUT_MS`=20, `ERR_HOLD_MS`=5.
- Normal trial: reset, start rise, wait for GO -> `start_timer` pulses once, `led`=1, time in WAIT = (10+lfsr[2:0])*4 ±1 cycles. React with `ms_time`=7 -> `stop_timer` pulse, RESULT, `result`=7, `best`=7, `done`=1.
- Best tracking: trials reacting at `ms_time` 12, then 5, then 9 -> `result` reads 12, 5, 9; `best` reads 7, 5, 5.
- False start: react rise 3 ms into WAIT -> FALSE_START with `show_error`=1 for 20 cycles, no `start_timer` pulse, start presses ignored, then IDLE with `result` and `best` unchanged.
- Timeout and ties: no react in GO -> TIMEOUT after 80 cycles with a `stop_timer` pulse. Separately, react rise in the same cycle as the final WAIT tick -> FALSE_START.
- Saturation and reset: `ms_time`=12000 at react -> `result`=9999. Assert `reset` mid-GO -> next cycle shows all outputs at reset values, `best`=9999, state 0.

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg
// Shared definitions for the reaction-time trial sequencer. It holds the state
// encoding, the display and best-time limits, the time width, and the LFSR
// seed, tap mask and step function.
package reaction_pkg;

    localparam int TIME_W = 14;

    localparam logic [TIME_W-1:0] BEST_RESET = 14'd9999;
    localparam logic [TIME_W-1:0] DISP_MAX   = 14'd9999;

    // Galois form of x^16+x^14+x^13+x^11 for a right-shifting register.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT        = 3'd1,
        ST_GO          = 3'd2,
        ST_RESULT      = 3'd3,
        ST_FALSE_START = 3'd4,
        ST_TIMEOUT     = 3'd5
    } state_t;

    // A nonzero state never steps to zero, so no lock-up guard is needed.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen
// Clearable clock divider that produces a one-cycle millisecond strobe.
// Ports:
//   clk   in  : system clock
//   reset in  : synchronous active-high reset
//   clr   in  : restarts the divider at 0 on the next edge
//   tick  out : high for one cycle while the divider sits at TICK_DIV-1
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign tick = (r_div == DIV_LAST);

endmodule

// File: rtl/reaction_trial_sequencer.sv
// reaction_trial_sequencer
// Runs one reaction-time trial: arm on a start press, wait a pseudo-random
// foreperiod, light the go LED and start the external ms timer, then stop it
// on the react press or on timeout. False starts and timeouts hold an error
// indication for a fixed time. Tracks the best valid time since reset.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start_btn, react_btn  : debounced button levels (rising edges are used)
//   ms_time               : running ms count from the external timer
//   start_timer           : one-cycle pulse clearing/starting the timer
//   stop_timer            : one-cycle pulse freezing the timer
//   led                   : go light
//   show_error            : high in FALSE_START or TIMEOUT
//   done                  : high in RESULT
//   result, best          : last valid time and session minimum (ms)
//   state_out             : current state encoding
module reaction_trial_sequencer
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 2000,
    parameter int ERR_HOLD_MS  = 1500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_btn,
    input  logic              react_btn,
    input  logic [TIME_W-1:0] ms_time,
    output logic              start_timer,
    output logic              stop_timer,
    output logic              led,
    output logic              show_error,
    output logic              done,
    output logic [TIME_W-1:0] result,
    output logic [TIME_W-1:0] best,
    output logic [2:0]        state_out
);

    state_t            r_state;
    logic              r_start_q1, r_start_q2;
    logic              r_react_q1, r_react_q2;
    logic [15:0]       r_lfsr;
    logic [TIME_W-1:0] r_target;
    logic [TIME_W-1:0] r_ms;
    logic              r_start_timer, r_stop_timer, r_led, r_show_error, r_done;
    logic [TIME_W-1:0] r_result, r_best;

    logic              w_start_rise, w_react_rise, w_tick, w_clr;
    logic              w_wait_done, w_go_timeout, w_hold_done;
    logic [TIME_W-1:0] w_sat;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Each phase ends on the tick that completes its N-th millisecond, so a
    // phase of N ms lasts exactly N*TICK_DIV cycles after the clear.
    always_comb begin
        w_start_rise = r_start_q1 & ~r_start_q2;
        w_react_rise = r_react_q1 & ~r_react_q2;
        w_wait_done  = w_tick && (r_ms == r_target - TIME_W'(1));
        w_go_timeout = w_tick && (r_ms == TIME_W'(TIMEOUT_MS - 1));
        w_hold_done  = w_tick && (r_ms == TIME_W'(ERR_HOLD_MS - 1));
        w_sat        = (ms_time > DISP_MAX) ? DISP_MAX : ms_time;
        // Divider and ms counter restart on every entry into a timed phase.
        w_clr = (((r_state == ST_IDLE) || (r_state == ST_RESULT)) && w_start_rise)
             || ((r_state == ST_WAIT) && (w_react_rise || w_wait_done))
             || ((r_state == ST_GO) && !w_react_rise && w_go_timeout);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_q1 <= 1'b0;
            r_start_q2 <= 1'b0;
            r_react_q1 <= 1'b0;
            r_react_q2 <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_ms       <= '0;
        end else begin
            r_start_q1 <= start_btn;
            r_start_q2 <= r_start_q1;
            r_react_q1 <= react_btn;
            r_react_q2 <= r_react_q1;
            r_lfsr     <= lfsr_next(r_lfsr);
            if (w_clr) begin
                r_ms <= '0;
            end else if (w_tick && (r_ms != '1)) begin
                r_ms <= r_ms + TIME_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_target      <= '0;
            r_start_timer <= 1'b0;
            r_stop_timer  <= 1'b0;
            r_led         <= 1'b0;
            r_show_error  <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_best        <= BEST_RESET;
        end else begin
            r_start_timer <= 1'b0;
            r_stop_timer  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESULT: begin
                    if (w_start_rise) begin
                        r_state  <= ST_WAIT;
                        r_target <= TIME_W'(MIN_DELAY_MS) + TIME_W'(r_lfsr[RAND_BITS-1:0]);
                        r_done   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A press in the final foreperiod cycle is still early.
                    if (w_react_rise) begin
                        r_state      <= ST_FALSE_START;
                        r_show_error <= 1'b1;
                    end else if (w_wait_done) begin
                        r_state       <= ST_GO;
                        r_led         <= 1'b1;
                        r_start_timer <= 1'b1;
                    end
                end
                ST_GO: begin
                    if (w_react_rise) begin
                        r_state      <= ST_RESULT;
                        r_led        <= 1'b0;
                        r_done       <= 1'b1;
                        r_stop_timer <= 1'b1;
                        r_result     <= w_sat;
                        if (w_sat < r_best) begin
                            r_best <= w_sat;
                        end
                    end else if (w_go_timeout) begin
                        r_state      <= ST_TIMEOUT;
                        r_led        <= 1'b0;
                        r_show_error <= 1'b1;
                        r_stop_timer <= 1'b1;
                    end
                end
                ST_FALSE_START, ST_TIMEOUT: begin
                    if (w_hold_done) begin
                        r_state      <= ST_IDLE;
                        r_show_error <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_led        <= 1'b0;
                    r_show_error <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign start_timer = r_start_timer;
    assign stop_timer  = r_stop_timer;
    assign led         = r_led;
    assign show_error  = r_show_error;
    assign done        = r_done;
    assign result      = r_result;
    assign best        = r_best;
    assign state_out   = r_state;

endmodule

// File: tb/tb_reaction_trial_sequencer.sv
// tb_reaction_trial_sequencer
// Self-checking bench for reaction_trial_sequencer with small timing
// parameters. Inputs are driven and outputs sampled on the falling edge.
module tb_reaction_trial_sequencer;

    localparam int TICK_DIV     = 4;
    localparam int MIN_DELAY_MS = 10;
    localparam int RAND_BITS    = 3;
    localparam int TIMEOUT_MS   = 20;
    localparam int ERR_HOLD_MS  = 5;

    localparam int S_IDLE = 0, S_WAIT = 1, S_GO = 2, S_RESULT = 3, S_FS = 4, S_TO = 5;

    logic        clk, reset, start_btn, react_btn;
    logic [13:0] ms_time;
    logic        start_timer, stop_timer, led, show_error, done;
    logic [13:0] result, best;
    logic [2:0]  state_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] exp_result_q[$];
    logic [13:0] exp_best_q[$];
    logic [13:0] m_best;
    logic [13:0] m_result;
    logic [15:0] m_lfsr;

    reaction_trial_sequencer #(
        .TICK_DIV     (TICK_DIV),
        .MIN_DELAY_MS (MIN_DELAY_MS),
        .RAND_BITS    (RAND_BITS),
        .TIMEOUT_MS   (TIMEOUT_MS),
        .ERR_HOLD_MS  (ERR_HOLD_MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .react_btn   (react_btn),
        .ms_time     (ms_time),
        .start_timer (start_timer),
        .stop_timer  (stop_timer),
        .led         (led),
        .show_error  (show_error),
        .done        (done),
        .result      (result),
        .best        (best),
        .state_out   (state_out)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: right-shifting Galois form of x^16+x^14+x^13+x^11.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_for_state(input int s, input int budget);
        int k;
        k = 0;
        while (32'(state_out) != s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("reach_state_%0d", s), 32'(state_out), s);
    endtask

    task automatic count_state(input int s, input int limit, output int n);
        n = 0;
        while (32'(state_out) == s && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Press start; returns the foreperiod the DUT should latch, in ms.
    task automatic arm_trial(output int t_exp);
        @(negedge clk);
        start_btn = 1'b1;
        @(posedge clk);
        #1;
        t_exp = MIN_DELAY_MS + int'(m_lfsr[RAND_BITS-1:0]);
        @(negedge clk);
        start_btn = 1'b0;
        wait_for_state(S_WAIT, 4);
    endtask

    // Called on a GO negedge: press react with the given timer value.
    task automatic react_at(input logic [13:0] v);
        logic [13:0] r;
        r = (v > 14'd9999) ? 14'd9999 : v;
        exp_result_q.push_back(r);
        if (r < m_best) m_best = r;
        exp_best_q.push_back(m_best);
        ms_time   = v;
        react_btn = 1'b1;
        @(negedge clk);
        check("start_timer_low_in_go", start_timer, 0);
        wait_for_state(S_RESULT, 3);
        check("stop_timer_pulse", stop_timer, 1);
        check("done_in_result", done, 1);
        check("led_off_in_result", led, 0);
        if (exp_result_q.size() > 0) begin
            m_result = exp_result_q.pop_front();
            check("result", result, m_result);
            check("best", best, exp_best_q.pop_front());
        end
        @(negedge clk);
        react_btn = 1'b0;
        check("stop_timer_one_cycle", stop_timer, 0);
        check("result_held", 32'(state_out), S_RESULT);
    endtask

    task automatic go_and_check_wait(output int t);
        int n;
        arm_trial(t);
        count_state(S_WAIT, 400, n);
        check($sformatf("wait_len_%0d_near_%0d", n, t * TICK_DIV),
              32'((n >= t * TICK_DIV - 1) && (n <= t * TICK_DIV + 1)), 1);
        check("go_state", 32'(state_out), S_GO);
        check("start_timer_pulse", start_timer, 1);
        check("led_on_in_go", led, 1);
        check("no_stop_in_first_go", stop_timer, 0);
    endtask

    initial begin
        int t, n, bad, st;
        logic [13:0] react_vals [4];
        react_vals[0] = 14'd7;
        react_vals[1] = 14'd12;
        react_vals[2] = 14'd5;
        react_vals[3] = 14'd9;

        reset = 1'b1; start_btn = 1'b0; react_btn = 1'b0; ms_time = '0;
        m_best = 14'd9999; m_result = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_out), S_IDLE);
        check("rst_best", best, 9999);
        check("rst_result", result, 0);
        check("rst_flags", {start_timer, stop_timer, led, show_error, done}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // React in IDLE is ignored.
        react_btn = 1'b1;
        repeat (3) @(negedge clk);
        react_btn = 1'b0;
        check("idle_react_ignored", 32'(state_out), S_IDLE);

        // Normal trial followed by best-time tracking.
        foreach (react_vals[i]) begin
            go_and_check_wait(t);
            react_at(react_vals[i]);
        end

        // False start 3 ms into WAIT; start presses ignored during the hold.
        arm_trial(t);
        repeat (3 * TICK_DIV) @(negedge clk);
        react_btn = 1'b1;
        wait_for_state(S_FS, 4);
        n = 0; bad = 0; st = 0;
        while (32'(state_out) == S_FS && n < 100) begin
            if (show_error !== 1'b1) bad++;
            if (start_timer) st++;
            if (n == 1) react_btn = 1'b0;
            if (n == 3) start_btn = 1'b1;
            if (n == 5) start_btn = 1'b0;
            n++;
            @(negedge clk);
        end
        check("fs_hold_len", n, ERR_HOLD_MS * TICK_DIV);
        check("fs_show_error", bad, 0);
        check("fs_no_start_timer", st, 0);
        check("fs_to_idle", 32'(state_out), S_IDLE);
        check("fs_err_clear", show_error, 0);
        check("fs_result_kept", result, m_result);
        check("fs_best_kept", best, m_best);
        repeat (3) @(negedge clk);
        check("fs_start_edge_dropped", 32'(state_out), S_IDLE);

        // Timeout: no react in GO.
        go_and_check_wait(t);
        count_state(S_GO, 200, n);
        check("go_len_to_timeout", n, TIMEOUT_MS * TICK_DIV);
        check("timeout_state", 32'(state_out), S_TO);
        check("timeout_stop_pulse", stop_timer, 1);
        check("timeout_show_error", show_error, 1);
        check("timeout_led_off", led, 0);
        check("timeout_result_kept", result, m_result);
        check("timeout_best_kept", best, m_best);
        count_state(S_TO, 100, n);
        check("timeout_hold_len", n, ERR_HOLD_MS * TICK_DIV);
        check("timeout_to_idle", 32'(state_out), S_IDLE);

        // Tie: react rise lands in the final WAIT cycle.
        arm_trial(t);
        for (int i = 1; i < t * TICK_DIV - 1; i++) @(negedge clk);
        react_btn = 1'b1;
        repeat (2) @(negedge clk);
        check("tie_goes_false_start", 32'(state_out), S_FS);
        check("tie_no_start_timer", start_timer, 0);
        react_btn = 1'b0;
        count_state(S_FS, 100, n);
        check("tie_back_idle", 32'(state_out), S_IDLE);

        // Saturation of the displayed result.
        go_and_check_wait(t);
        react_at(14'd12000);

        // Reset in the middle of GO.
        go_and_check_wait(t);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midgo_rst_state", 32'(state_out), S_IDLE);
        check("midgo_rst_best", best, 9999);
        check("midgo_rst_result", result, 0);
        check("midgo_rst_flags", {start_timer, stop_timer, led, show_error, done}, 0);
        reset = 1'b0;
        m_best = 14'd9999;
        @(negedge clk);

        // Fresh session: LFSR reseeded and best restarts from 9999.
        go_and_check_wait(t);
        react_at(14'd8);

        check("scoreboard_drained", exp_result_q.size() + exp_best_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
